// File: rtl/bfly_egress.sv
// Egress buffer behind the butterfly network: one header-checked FWFT FIFO per output lane.
// Words whose header names another lane are dropped, pulsed on err and tallied in err_cnt.
module bfly_egress #(
    parameter int DW    = 35,
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N-1:0]                   i_valid,
    output logic [N-1:0]                   i_ready,
    input  logic [N*DW-1:0]                i_data,
    output logic [N-1:0]                   o_valid,
    input  logic [N-1:0]                   o_ready,
    output logic [N*(DW-$clog2(N))-1:0]    o_data,
    output logic [N-1:0]                   err,
    output logic [CW-1:0]                  err_cnt,
    output logic [N*CW-1:0]                pkt_cnt
);
    localparam int AW   = $clog2(N);
    localparam int PW   = DW - AW;
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH) + 1;
    localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

    logic [N-1:0]  miss;
    logic [CW-1:0] err_cnt_reg;
    logic [CW:0]   miss_total;
    logic [CW:0]   err_sum;

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        localparam logic [AW-1:0] LANE = AW'(gi);

        logic [PW-1:0]   mem [DEPTH];
        logic [PTRW-1:0] wr_ptr_reg;
        logic [PTRW-1:0] rd_ptr_reg;
        logic [CNTW-1:0] count_reg;
        logic [CW-1:0]   pkt_cnt_reg;
        logic            err_reg;
        logic [DW-1:0]   word;
        logic            accept;
        logic            push;
        logic            pop;

        assign word        = i_data[gi*DW +: DW];
        assign i_ready[gi] = (count_reg != FULL);
        assign o_valid[gi] = (count_reg != '0);
        assign accept      = i_valid[gi] && i_ready[gi];
        assign push        = accept && (word[DW-1 -: AW] == LANE);
        assign miss[gi]    = accept && (word[DW-1 -: AW] != LANE);
        assign pop         = o_valid[gi] && o_ready[gi];

        // Storage is deliberately left out of reset so it maps onto plain RAM.
        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr_reg] <= word[PW-1:0];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_reg  <= '0;
                rd_ptr_reg  <= '0;
                count_reg   <= '0;
                pkt_cnt_reg <= '0;
                err_reg     <= 1'b0;
            end else begin
                err_reg <= miss[gi];
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + PTRW'(1);
                end
                if (pop) begin
                    rd_ptr_reg  <= rd_ptr_reg + PTRW'(1);
                    pkt_cnt_reg <= pkt_cnt_reg + CW'(1);
                end
                case ({push, pop})
                    2'b10:   count_reg <= count_reg + CNTW'(1);
                    2'b01:   count_reg <= count_reg - CNTW'(1);
                    default: count_reg <= count_reg;
                endcase
            end
        end

        // Gate the read with o_valid so an empty lane presents zeros rather than stale RAM.
        assign o_data[gi*PW +: PW]  = o_valid[gi] ? mem[rd_ptr_reg] : '0;
        assign err[gi]              = err_reg;
        assign pkt_cnt[gi*CW +: CW] = pkt_cnt_reg;
    end

    always_comb begin
        miss_total = '0;
        for (int k = 0; k < N; k++) begin
            miss_total = miss_total + (CW+1)'(miss[k]);
        end
    end

    assign err_sum = {1'b0, err_cnt_reg} + miss_total;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg <= '0;
        end else if (err_sum[CW]) begin
            err_cnt_reg <= '1;
        end else begin
            err_cnt_reg <= err_sum[CW-1:0];
        end
    end

    assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_bfly_egress.sv
// Bench for bfly_egress: queue-based reference model compared every cycle, plus directed literal checks.
module tb_bfly_egress;
    localparam int N     = 8;
    localparam int DW    = 35;
    localparam int PW    = 32;
    localparam int CW    = 16;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      i_valid;
    logic [N-1:0]      i_ready;
    logic [N*DW-1:0]   i_data;
    logic [N-1:0]      o_valid;
    logic [N-1:0]      o_ready;
    logic [N*PW-1:0]   o_data;
    logic [N-1:0]      err;
    logic [CW-1:0]     err_cnt;
    logic [N*CW-1:0]   pkt_cnt;

    int vectors = 0;
    int fails   = 0;

    logic [PW-1:0] mq [N][$];
    logic [CW-1:0] m_pkt [N];
    logic [N-1:0]  m_err;
    int            m_err_cnt;
    logic [PW-1:0] lane1_log [$];

    bfly_egress #(.DW(DW), .N(N), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
        .err(err), .err_cnt(err_cnt), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] odata(input int lane);
        return o_data[lane*PW +: PW];
    endfunction

    function automatic logic [CW-1:0] pcnt(input int lane);
        return pkt_cnt[lane*CW +: CW];
    endfunction

    task automatic set_word(input int lane, input logic [2:0] h, input logic [PW-1:0] p);
        i_data[lane*DW +: DW] = {h, p};
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            mq[i].delete();
            m_pkt[i] = '0;
        end
        m_err     = '0;
        m_err_cnt = 0;
    endtask

    // Reference model: per-lane queues updated from the inputs seen at each edge.
    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_clear();
            end else begin
                logic [N-1:0] nerr;
                int miss;
                nerr = '0;
                miss = 0;
                for (int i = 0; i < N; i++) begin
                    int sz;
                    logic [DW-1:0] w;
                    sz = mq[i].size();
                    w  = i_data[i*DW +: DW];
                    if (sz != 0 && o_ready[i]) begin
                        void'(mq[i].pop_front());
                        m_pkt[i] = m_pkt[i] + 16'd1;
                    end
                    if (i_valid[i] && sz != DEPTH) begin
                        if (w[DW-1 -: 3] == 3'(i)) begin
                            mq[i].push_back(w[PW-1:0]);
                        end else begin
                            nerr[i] = 1'b1;
                            miss++;
                        end
                    end
                end
                m_err     = nerr;
                m_err_cnt = (m_err_cnt + miss > 65535) ? 65535 : m_err_cnt + miss;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (rst_n && o_valid[1] && o_ready[1]) begin
                lane1_log.push_back(odata(1));
            end
        end
    end

    // Per-cycle comparison against the model, just after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                chk("i_ready", 64'(i_ready[i]), 64'(mq[i].size() != DEPTH));
                chk("o_valid", 64'(o_valid[i]), 64'(mq[i].size() != 0));
                if (mq[i].size() != 0) begin
                    chk("o_data", 64'(odata(i)), 64'(mq[i][0]));
                end
                chk("err", 64'(err[i]), 64'(m_err[i]));
                chk("pkt_cnt", 64'(pcnt(i)), 64'(m_pkt[i]));
            end
            chk("err_cnt", 64'(err_cnt), 64'(m_err_cnt));
        end
    end

    initial begin
        int  w;
        bit  acc;
        rst_n   = 1'b0;
        i_valid = '0;
        i_data  = '0;
        o_ready = '1;

        // Reset state
        #100;
        chk("rst_i_ready", 64'(i_ready), 64'(8'hFF));
        chk("rst_o_valid", 64'(o_valid), 64'(0));
        chk("rst_err_cnt", 64'(err_cnt), 64'(0));
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
        chk("rst_o_data", 64'(o_data), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single correctly-routed word on lane 6
        @(negedge clk);
        i_valid[6] = 1'b1;
        set_word(6, 3'd6, 32'h1234);
        @(posedge clk); #1;
        chk("sr_valid", 64'(o_valid[6]), 64'(1));
        chk("sr_data", 64'(odata(6)), 64'(32'h1234));
        chk("sr_others", 64'(o_valid & 8'hBF), 64'(0));
        @(negedge clk);
        i_valid = '0;
        @(posedge clk); #1;
        chk("sr_drained", 64'(o_valid[6]), 64'(0));
        chk("sr_pkt_cnt", 64'(pcnt(6)), 64'(1));

        // Misroutes: single lane, then two lanes in one cycle
        @(negedge clk);
        chk("mr_ready", 64'(i_ready[6]), 64'(1));
        i_valid[6] = 1'b1;
        set_word(6, 3'd2, 32'hDEAD);
        @(posedge clk); #1;
        chk("mr_err6", 64'(err), 64'(8'h40));
        chk("mr_err_cnt1", 64'(err_cnt), 64'(1));
        chk("mr_no_valid", 64'(o_valid[6]), 64'(0));
        @(negedge clk);
        i_valid = 8'b0000_1001;
        set_word(0, 3'd5, 32'hBAD0);
        set_word(3, 3'd0, 32'hBAD3);
        @(posedge clk); #1;
        chk("mr_err03", 64'(err), 64'(8'h09));
        chk("mr_err_cnt3", 64'(err_cnt), 64'(3));
        @(negedge clk);
        i_valid = '0;
        @(posedge clk); #1;
        chk("mr_err_clear", 64'(err), 64'(0));

        // Backpressure on lane 1
        @(negedge clk);
        o_ready[1] = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            i_valid[1] = 1'b1;
            set_word(1, 3'd1, 32'(v));
            @(negedge clk);
        end
        chk("bp_full", 64'(i_ready[1]), 64'(0));
        set_word(1, 3'd1, 32'h5);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_held", 64'(i_ready[1]), 64'(0));
            chk("bp_stable", 64'(odata(1)), 64'(32'h1));
        end
        o_ready[1] = 1'b1;
        w   = 0;
        acc = 1'b0;
        while (!acc && w < 10) begin
            acc = i_ready[1];
            @(negedge clk);
            w++;
        end
        chk("bp_accept5", 64'(acc), 64'(1));
        i_valid[1] = 1'b0;
        repeat (8) @(negedge clk);
        chk("bp_count", 64'(lane1_log.size()), 64'(5));
        for (int k = 0; k < 5; k++) begin
            if (k < lane1_log.size()) begin
                chk("bp_order", 64'(lane1_log[k]), 64'(k + 1));
            end
        end
        chk("bp_pkt_cnt", 64'(pcnt(1)), 64'(5));

        // Simultaneous push/pop on lane 2 with two words resident
        o_ready[2] = 1'b0;
        i_valid[2] = 1'b1;
        set_word(2, 3'd2, 32'hC000_0000);
        @(negedge clk);
        set_word(2, 3'd2, 32'hC000_0001);
        @(negedge clk);
        o_ready[2] = 1'b1;
        for (int j = 0; j < 10; j++) begin
            set_word(2, 3'd2, 32'hC000_0000 + 32'(j + 2));
            @(posedge clk); #1;
            chk("pp_ready", 64'(i_ready[2]), 64'(1));
            chk("pp_valid", 64'(o_valid[2]), 64'(1));
            @(negedge clk);
        end
        chk("pp_head", 64'(odata(2)), 64'(32'hC000_000A));
        i_valid[2] = 1'b0;
        repeat (4) @(negedge clk);
        chk("pp_pkt_cnt", 64'(pcnt(2)), 64'(12));

        // err_cnt saturation: every lane misroutes every cycle
        for (int i = 0; i < N; i++) begin
            set_word(i, 3'((i + 1) % N), 32'hE000_0000 + 32'(i));
        end
        i_valid = '1;
        repeat (8200) @(negedge clk);
        i_valid = '0;
        @(posedge clk); #1;
        chk("sat_err_cnt", 64'(err_cnt), 64'(16'hFFFF));

        // Reset mid-stream with three words queued on lane 4
        @(negedge clk);
        o_ready[4] = 1'b0;
        i_valid[4] = 1'b1;
        for (int v = 0; v < 3; v++) begin
            set_word(4, 3'd4, 32'hA400_0000 + 32'(v));
            @(negedge clk);
        end
        i_valid[4] = 1'b0;
        chk("ms_queued", 64'(o_valid[4]), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ms_o_valid", 64'(o_valid), 64'(0));
        chk("ms_i_ready", 64'(i_ready), 64'(8'hFF));
        chk("ms_err_cnt", 64'(err_cnt), 64'(0));
        chk("ms_pkt_cnt", 64'(pkt_cnt), 64'(0));
        chk("ms_err", 64'(err), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        o_ready = '1;
        @(negedge clk);
        i_valid[4] = 1'b1;
        set_word(4, 3'd4, 32'h4444);
        @(posedge clk); #1;
        chk("ms_new_valid", 64'(o_valid[4]), 64'(1));
        chk("ms_new_data", 64'(odata(4)), 64'(32'h4444));
        @(negedge clk);
        i_valid = '0;
        repeat (3) @(negedge clk);
        chk("ms_new_pkt", 64'(pcnt(4)), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bfly_egress.md
# bfly_egress

Per-output-port egress buffer placed directly downstream of the N-port butterfly network. Each lane accepts routed words on a valid/ready handshake, checks that the 3-bit destination header matches its own port index, strips the header, and queues the payload in a small first-word-fall-through FIFO for the consumer. Misrouted words are dropped and counted, so routing faults in the network are visible to software and the bench.

## Interface
- DW, 35, width of a routed word from the network: {dest[AW-1:0], payload[PW-1:0]}
- N, 8, number of ports; power of two
- AW, $clog2(N), header width (localparam, 3 at default)
- PW, DW-AW, payload width (localparam, 32 at default)
- DEPTH, 4, FIFO entries per lane; power of two, ≥2
- CW, 16, width of per-lane delivered-word counters and the misroute counter
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- i_valid  input  1 x [N]  word from network lane i valid
- i_ready  output  1 x [N]  lane i can accept
- i_data  input  DW x [N]  routed word from network lane i
- o_valid  output  1 x [N]  payload available on lane i
- o_ready  input  1 x [N]  consumer takes lane i payload
- o_data  output  PW x [N]  payload, header stripped
- err  output  1 x [N]  one-cycle pulse: lane i dropped a misrouted word
- err_cnt  output  CW  total misrouted words, all lanes
- pkt_cnt  output  CW x [N]  words delivered on lane i

## Operation
- Lanes are independent; no cross-lane ordering.
- Input accept on lane i: i_valid[i] && i_ready[i] at a rising edge.
- i_ready[i] = (count[i] != DEPTH), from registered state only; no combinational path from o_ready.
- On accept, header h = i_data[i][DW-1 -: AW]:
  - h == i: payload i_data[i][PW-1:0] written at wr_ptr, wr_ptr++ (wraps mod DEPTH).
  - h != i: word dropped, FIFO untouched, err[i]=1 next cycle, err_cnt += 1.
- Output: o_valid[i] = (count[i] != 0); o_data[i] = mem[rd_ptr] (FWFT). Pop on o_valid && o_ready: rd_ptr++ (wraps), pkt_cnt[i] += 1.
- Push and pop in the same cycle: both take effect, count unchanged. Full lane: no push even if popping that cycle.
- Counters: pkt_cnt wraps mod 2^CW. err_cnt saturates at 2^CW−1. Multiple lanes misrouting in one cycle add their total (popcount) to err_cnt.
- o_data holding an empty lane: value is don't-care; the bench checks it only while o_valid.

## Timing
- Reset (async assert, sync-safe deassert): all pointers/counts 0; i_ready all 1; o_valid all 0; o_data all 0; err all 0; err_cnt 0; pkt_cnt all 0. FIFO contents are not reset.
- Reset mid-operation: queued words lost, counters cleared, no err pulse.
- Latency: word accepted at edge k → o_valid/o_data visible after edge k (cycle k+1). Minimum one cycle, no bypass.
- Throughput: one word per cycle per lane with o_ready held high.
- err[i] high exactly one cycle per dropped word; err_cnt updated on the same edge.
- o_valid never drops without a pop; o_data stable while o_valid && !o_ready.

## Test plan
- Reset: hold rst_n low 100 ns → i_ready all 1, o_valid all 0, err_cnt 0, pkt_cnt all 0.
- Single route: lane 6 i_data={3'd6,32'h1234} for one beat, o_ready all 1 → o_valid[6] high one cycle later with o_data[6]=32'h1234, then low; pkt_cnt[6]=1; other lanes idle.
- Misroute: lane 6 i_data={3'd2,32'hDEAD} → accepted (i_ready=1), o_valid[6] stays 0, err[6] pulses one cycle, err_cnt=1; with simultaneous misroutes on lanes 0 and 3, err_cnt += 2 in one cycle.
- Backpressure: o_ready[1]=0, push 32'h1..32'h5 on lane 1 with header 1 → first four accepted, i_ready[1]=0 after the fourth, fifth held; release o_ready → outputs 1,2,3,4,5 in order, pkt_cnt[1]=5.
- Simultaneous push/pop: lane 2 holding 2 words, push and pop in the same cycle for 10 cycles → count stays 2, order preserved, pointers wrap with no loss.
- Reset mid-stream: lane 4 holding 3 words, assert rst_n → o_valid[4]=0 immediately, all counters 0; after release the lane accepts a new word normally.
